duck_round_controller: RTL and testbench
========================================

Name: duck_round_controller

Overview:
- Sequences the GAME phase of the top-level game state machine: owns the round countdown, the 1 s timebase, duck spawn scheduling towards the duck drawer and the hit score.
- Sits between the top-level state register (state_in) and the duck draw/mouse-hit datapath.
- Supplies the end-of-time flag that moves the top level from GAME to SCORE.
- Supplies the score shown on the SCORE screen.

Parameters:
- CLK_HZ, 65_000_000: pclk cycles per second tick.
- GAME_TIME, 60: round length in seconds (1..127).
- SPAWN_GAP_CYC, 32_500_000: pclk cycles between end of one duck and the next spawn request.
- SCORE_MAX, 999: score saturation value.

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst_d  in  1  synchronous, active-low reset
- state_in  in  2  top-level state; GAME = 2'b10
- duck_hit  in  1  1-cycle pulse: click landed on active duck
- duck_escaped  in  1  1-cycle pulse: active duck left the screen
- spawn_ack  in  1  duck drawer accepted spawn request
- spawn_req  out  1  request to launch a duck
- duck_hstart  out  11  launch x position, valid while spawn_req=1
- duck_active  out  1  a duck is in flight
- time_left  out  7  seconds remaining
- score  out  10  ducks hit this round
- end_of_time  out  1  round expired

Behaviour:
- Reset (rst_d=0 at a pclk edge):
  - FSM to OFF; prescaler and gap counter to 0; LFSR to 10'h2A5.
  - All outputs 0.
- FSM states and transitions:
  - OFF: idle. On state_in==GAME: time_left<=GAME_TIME, score<=0, end_of_time<=0, prescaler<=0, gap<=0, go to ARM.
  - ARM: gap counter increments each cycle. On reaching SPAWN_GAP_CYC-1: latch duck_hstart<={1'b0,lfsr}, spawn_req<=1, go to SPAWN.
  - SPAWN: hold spawn_req and duck_hstart stable. When spawn_ack=1 is sampled: spawn_req<=0, duck_active<=1, go to FLY. Registered, so spawn_req falls the cycle after ack.
  - FLY, on duck_hit: score<=min(score+1,SCORE_MAX), duck_active<=0, gap<=0, go to ARM.
  - FLY, on duck_escaped: same as duck_hit but score unchanged.
  - FLY, duck_hit and duck_escaped in the same cycle: treated as a hit.
  - DONE: end_of_time=1 held; no spawns; score and time_left frozen.
- Timebase:
  - Prescaler counts 0..CLK_HZ-1 in ARM, SPAWN and FLY only.
  - At wrap, sec_tick=1 for one cycle; time_left decrements.
- Expiry: a sec_tick with time_left==1 sets time_left<=0, end_of_time<=1, spawn_req<=0, duck_active<=0, go to DONE.
  - Expiry overrides the ARM, SPAWN and FLY transitions in that cycle.
  - A duck_hit in the expiry cycle still scores.
- LFSR:
  - 10-bit Fibonacci, x^10+x^7+1, shifts every cycle in all states except reset.
  - Never zero.
- Leaving GAME: state_in != GAME in any non-OFF state goes to OFF next cycle.
  - spawn_req, duck_active and end_of_time drop to 0.
  - score and time_left hold their values for the SCORE screen; they clear only on the next GAME entry or on reset.
- Ignored inputs:
  - duck_hit and duck_escaped outside FLY.
  - spawn_ack outside SPAWN.
- Reset mid-operation: forces OFF and all outputs to 0 regardless of state_in. GAME entry is re-detected after release.

Test Plan (CLK_HZ=10, GAME_TIME=3, SPAWN_GAP_CYC=4):
- Reset release with state_in=GAME: cycle 1 time_left=3, score=0; spawn_req=1 four cycles after ARM entry; duck_hstart matches the reference LFSR model.
- Acknowledge and hit: spawn_ack held 0 for 5 cycles, then 1 → spawn_req stays 1 with stable duck_hstart, then drops; duck_active=1 next cycle. A duck_hit pulse → score=1, duck_active=0, new spawn_req after 4 cycles.
- Simultaneous events: duck_hit and duck_escaped in the same cycle → score increments by 1. A duck_escaped alone → score unchanged, new spawn follows.
- Round expiry: after 30 active cycles time_left goes 3→2→1→0, then end_of_time=1, spawn_req=0 and duck_active=0 in the same cycle. A duck_hit in the expiry cycle → counted. Later duck_hit pulses → no effect.
- Leave and re-enter GAME: state_in to SCORE mid-FLY → next cycle OFF, duck_active=0, score and time_left retained. Back to GAME → score=0, time_left=3.
- Mid-round reset: rst_d=0 for 1 cycle during SPAWN → all outputs 0 next edge; spawn_ack pulses while in OFF → ignored.
- Saturation: SCORE_MAX=2 with three hits → score stays at 2.

Source files
------------

// File: rtl/duck_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : duck_round_controller
//  Description : Runs one GAME round: 1 s timebase and countdown, duck spawn
//                scheduling towards the duck drawer, and the saturating hit
//                score shown afterwards on the SCORE screen.
//  Revision    : 1.0 - initial release
// ============================================================================
module duck_round_controller #(
    parameter int CLK_HZ        = 65_000_000,
    parameter int GAME_TIME     = 60,
    parameter int SPAWN_GAP_CYC = 32_500_000,
    parameter int SCORE_MAX     = 999
) (
    input  logic        pclk,
    input  logic        rst_d,
    input  logic [1:0]  state_in,
    input  logic        duck_hit,
    input  logic        duck_escaped,
    input  logic        spawn_ack,
    output logic        spawn_req,
    output logic [10:0] duck_hstart,
    output logic        duck_active,
    output logic [6:0]  time_left,
    output logic [9:0]  score,
    output logic        end_of_time
);

    localparam logic [1:0] c_GAME      = 2'b10;
    localparam int         c_PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int         c_GAP_W     = (SPAWN_GAP_CYC > 1) ? $clog2(SPAWN_GAP_CYC) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLK_HZ - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'(SPAWN_GAP_CYC - 1);
    localparam logic [9:0] c_SCORE_MAX = 10'(SCORE_MAX);
    localparam logic [6:0] c_GAME_TIME = 7'(GAME_TIME);
    localparam logic [9:0] c_LFSR_SEED = 10'h2A5;

    localparam logic [2:0] c_ST_OFF   = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_SPAWN = 3'd2;
    localparam logic [2:0] c_ST_FLY   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]           r_state;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_GAP_W-1:0]   r_gap;
    logic [9:0]           r_lfsr;
    logic                 r_spawn_req;
    logic [10:0]          r_duck_hstart;
    logic                 r_duck_active;
    logic [6:0]           r_time_left;
    logic [9:0]           r_score;
    logic                 r_end_of_time;

    logic       w_in_game;
    logic       w_running;
    logic       w_sec_tick;
    logic       w_expire;
    logic       w_fly_hit;
    logic [9:0] w_score_inc;

    assign w_in_game   = (state_in == c_GAME);
    assign w_running   = (r_state == c_ST_ARM) || (r_state == c_ST_SPAWN) || (r_state == c_ST_FLY);
    assign w_sec_tick  = w_running && (r_presc == c_PRESC_LAST);
    // The last second running out ends the round regardless of duck activity.
    assign w_expire    = w_sec_tick && (r_time_left == 7'd1);
    // A hit and an escape in the same cycle count as a hit.
    assign w_fly_hit   = (r_state == c_ST_FLY) && duck_hit;
    assign w_score_inc = (r_score >= c_SCORE_MAX) ? c_SCORE_MAX : (r_score + 10'd1);

    // Free-running x^10+x^7+1 LFSR supplying launch positions; seed is nonzero.
    always_ff @(posedge pclk) begin
        if (!rst_d) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

    // Round sequencer: state, timebase, spawn gap, score and registered outputs.
    always_ff @(posedge pclk) begin
        if (!rst_d) begin
            r_state       <= c_ST_OFF;
            r_presc       <= '0;
            r_gap         <= '0;
            r_spawn_req   <= 1'b0;
            r_duck_hstart <= '0;
            r_duck_active <= 1'b0;
            r_time_left   <= '0;
            r_score       <= '0;
            r_end_of_time <= 1'b0;
        end else if ((r_state != c_ST_OFF) && !w_in_game) begin
            // Leaving GAME keeps score and time for the SCORE screen.
            r_state       <= c_ST_OFF;
            r_spawn_req   <= 1'b0;
            r_duck_active <= 1'b0;
            r_end_of_time <= 1'b0;
        end else begin
            if (w_running) begin
                r_presc <= w_sec_tick ? '0 : (r_presc + c_PRESC_W'(1));
            end
            case (r_state)
                c_ST_OFF: begin
                    if (w_in_game) begin
                        r_time_left   <= c_GAME_TIME;
                        r_score       <= '0;
                        r_end_of_time <= 1'b0;
                        r_presc       <= '0;
                        r_gap         <= '0;
                        r_state       <= c_ST_ARM;
                    end
                end
                c_ST_ARM, c_ST_SPAWN, c_ST_FLY: begin
                    if (w_expire) begin
                        r_time_left   <= '0;
                        r_end_of_time <= 1'b1;
                        r_spawn_req   <= 1'b0;
                        r_duck_active <= 1'b0;
                        r_state       <= c_ST_DONE;
                        if (w_fly_hit) begin
                            r_score <= w_score_inc;
                        end
                    end else begin
                        if (w_sec_tick) begin
                            r_time_left <= r_time_left - 7'd1;
                        end
                        case (r_state)
                            c_ST_ARM: begin
                                if (r_gap == c_GAP_LAST) begin
                                    r_duck_hstart <= {1'b0, r_lfsr};
                                    r_spawn_req   <= 1'b1;
                                    r_state       <= c_ST_SPAWN;
                                end else begin
                                    r_gap <= r_gap + c_GAP_W'(1);
                                end
                            end
                            c_ST_SPAWN: begin
                                if (spawn_ack) begin
                                    r_spawn_req   <= 1'b0;
                                    r_duck_active <= 1'b1;
                                    r_state       <= c_ST_FLY;
                                end
                            end
                            c_ST_FLY: begin
                                if (duck_hit || duck_escaped) begin
                                    if (w_fly_hit) begin
                                        r_score <= w_score_inc;
                                    end
                                    r_duck_active <= 1'b0;
                                    r_gap         <= '0;
                                    r_state       <= c_ST_ARM;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    // DONE: everything frozen until GAME is left.
                end
            endcase
        end
    end

    assign spawn_req   = r_spawn_req;
    assign duck_hstart = r_duck_hstart;
    assign duck_active = r_duck_active;
    assign time_left   = r_time_left;
    assign score       = r_score;
    assign end_of_time = r_end_of_time;

endmodule
`default_nettype wire

// File: tb/tb_duck_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_duck_round_controller
//  Description : Scoreboard bench for duck_round_controller: directed round
//                scenarios followed by random traffic, two score limits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_duck_round_controller;

    localparam int CLK_HZ    = 10;
    localparam int GAME_TIME = 3;
    localparam int GAP       = 4;
    localparam int SMAX_A    = 999;
    localparam int SMAX_B    = 2;
    localparam logic [1:0] GAME  = 2'b10;
    localparam logic [1:0] SCORE = 2'b11;

    localparam int P_OFF = 0, P_ARM = 1, P_SPAWN = 2, P_FLY = 3, P_DONE = 4;

    logic       pclk = 1'b0;
    logic       rst_d = 1'b0;
    logic [1:0] state_in = GAME;
    logic       duck_hit = 1'b0;
    logic       duck_escaped = 1'b0;
    logic       spawn_ack = 1'b0;

    logic        a_spawn_req, b_spawn_req;
    logic [10:0] a_duck_hstart, b_duck_hstart;
    logic        a_duck_active, b_duck_active;
    logic [6:0]  a_time_left, b_time_left;
    logic [9:0]  a_score, b_score;
    logic        a_end_of_time, b_end_of_time;

    always #5 pclk = ~pclk;

    duck_round_controller #(.CLK_HZ(CLK_HZ), .GAME_TIME(GAME_TIME),
                            .SPAWN_GAP_CYC(GAP), .SCORE_MAX(SMAX_A)) dut_a (
        .pclk(pclk), .rst_d(rst_d), .state_in(state_in), .duck_hit(duck_hit),
        .duck_escaped(duck_escaped), .spawn_ack(spawn_ack),
        .spawn_req(a_spawn_req), .duck_hstart(a_duck_hstart),
        .duck_active(a_duck_active), .time_left(a_time_left),
        .score(a_score), .end_of_time(a_end_of_time));

    duck_round_controller #(.CLK_HZ(CLK_HZ), .GAME_TIME(GAME_TIME),
                            .SPAWN_GAP_CYC(GAP), .SCORE_MAX(SMAX_B)) dut_b (
        .pclk(pclk), .rst_d(rst_d), .state_in(state_in), .duck_hit(duck_hit),
        .duck_escaped(duck_escaped), .spawn_ack(spawn_ack),
        .spawn_req(b_spawn_req), .duck_hstart(b_duck_hstart),
        .duck_active(b_duck_active), .time_left(b_time_left),
        .score(b_score), .end_of_time(b_end_of_time));

    typedef struct {
        int spawn;
        int hst;
        int duck;
        int tl;
        int sa;
        int sb;
        int eot;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model of the round, kept as phase plus elapsed-cycle counts.
    int         m_phase = P_OFF;
    int         m_act   = 0;
    int         m_arm   = 0;
    logic [9:0] m_lfsr  = 10'h2A5;
    snap_t      m_exp   = '{0, 0, 0, 0, 0, 0, 0};

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic model(input bit r, input logic [1:0] st, input bit h, input bit e, input bit a);
        logic [9:0] cur;
        cur    = m_lfsr;
        m_lfsr = r ? lfsr_next(m_lfsr) : 10'h2A5;
        if (!r) begin
            m_phase = P_OFF;
            m_exp   = '{0, 0, 0, 0, 0, 0, 0};
        end else if (m_phase != P_OFF && st != GAME) begin
            m_phase    = P_OFF;
            m_exp.spawn = 0;
            m_exp.duck  = 0;
            m_exp.eot   = 0;
        end else if (m_phase == P_OFF) begin
            if (st == GAME) begin
                m_phase    = P_ARM;
                m_exp.tl   = GAME_TIME;
                m_exp.sa   = 0;
                m_exp.sb   = 0;
                m_exp.eot  = 0;
                m_act      = 0;
                m_arm      = 0;
            end
        end else if (m_phase != P_DONE) begin
            m_act++;
            m_exp.tl = GAME_TIME - m_act / CLK_HZ;
            if (m_phase == P_FLY && h) begin
                m_exp.sa = (m_exp.sa + 1 > SMAX_A) ? SMAX_A : m_exp.sa + 1;
                m_exp.sb = (m_exp.sb + 1 > SMAX_B) ? SMAX_B : m_exp.sb + 1;
            end
            if (m_exp.tl == 0) begin
                m_phase     = P_DONE;
                m_exp.eot   = 1;
                m_exp.spawn = 0;
                m_exp.duck  = 0;
            end else begin
                case (m_phase)
                    P_ARM: begin
                        m_arm++;
                        if (m_arm == GAP) begin
                            m_exp.spawn = 1;
                            m_exp.hst   = int'(cur);
                            m_phase     = P_SPAWN;
                        end
                    end
                    P_SPAWN: begin
                        if (a) begin
                            m_exp.spawn = 0;
                            m_exp.duck  = 1;
                            m_phase     = P_FLY;
                        end
                    end
                    P_FLY: begin
                        if (h || e) begin
                            m_exp.duck = 0;
                            m_arm      = 0;
                            m_phase    = P_ARM;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    endtask

    task automatic step(input bit r, input logic [1:0] st, input bit h, input bit e, input bit a);
        @(negedge pclk);
        rst_d        = r;
        state_in     = st;
        duck_hit     = h;
        duck_escaped = e;
        spawn_ack    = a;
        model(r, st, h, e, a);
        exp_q.push_back(m_exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, GAME, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int phase, input bit a);
        int n;
        n = 0;
        while (m_phase != phase && n < 60) begin
            step(1'b1, GAME, 1'b0, 1'b0, a);
            n++;
        end
        if (m_phase != phase) begin
            total++;
            bad++;
            $display("FAIL steer: phase %0d reached instead of %0d", m_phase, phase);
        end
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared after the edge.
    initial begin
        snap_t s;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("a_spawn_req",   int'(a_spawn_req),   s.spawn);
                chk("a_duck_hstart", int'(a_duck_hstart), s.hst);
                chk("a_duck_active", int'(a_duck_active), s.duck);
                chk("a_time_left",   int'(a_time_left),   s.tl);
                chk("a_score",       int'(a_score),       s.sa);
                chk("a_end_of_time", int'(a_end_of_time), s.eot);
                chk("b_spawn_req",   int'(b_spawn_req),   s.spawn);
                chk("b_duck_hstart", int'(b_duck_hstart), s.hst);
                chk("b_duck_active", int'(b_duck_active), s.duck);
                chk("b_time_left",   int'(b_time_left),   s.tl);
                chk("b_score",       int'(b_score),       s.sb);
                chk("b_end_of_time", int'(b_end_of_time), s.eot);
            end
        end
    end

    initial begin
        // Reset, then release straight into GAME.
        step(1'b0, GAME, 1'b0, 1'b0, 1'b0);
        step(1'b0, GAME, 1'b0, 1'b0, 1'b0);
        step(1'b1, GAME, 1'b0, 1'b0, 1'b0);
        run_until(P_SPAWN, 1'b0);
        idle(5);
        step(1'b1, GAME, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b1, GAME, 1'b1, 1'b0, 1'b0);
        // Simultaneous hit and escape, then escape alone.
        run_until(P_FLY, 1'b1);
        step(1'b1, GAME, 1'b1, 1'b1, 1'b0);
        run_until(P_FLY, 1'b1);
        step(1'b1, GAME, 1'b0, 1'b1, 1'b0);
        // Land a hit exactly on the expiry cycle, then hits after DONE.
        run_until(P_FLY, 1'b1);
        while (m_phase == P_FLY && m_act < GAME_TIME * CLK_HZ - 1) idle(1);
        step(1'b1, GAME, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, GAME, 1'b1, 1'b0, 1'b1);
        // Leave to SCORE, re-enter, leave mid-flight, re-enter.
        for (int i = 0; i < 3; i++) step(1'b1, SCORE, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_until(P_FLY, 1'b1);
        step(1'b1, GAME, 1'b1, 1'b0, 1'b0);
        run_until(P_FLY, 1'b1);
        idle(2);
        step(1'b1, SCORE, 1'b0, 1'b0, 1'b0);
        step(1'b1, SCORE, 1'b1, 1'b0, 1'b1);
        idle(1);
        // Reset while a spawn is pending; acks in OFF are ignored.
        run_until(P_SPAWN, 1'b0);
        step(1'b0, GAME, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        // Saturation round: every duck acknowledged and hit immediately.
        for (int i = 0; i < 35; i++) step(1'b1, GAME, 1'b1, 1'b0, 1'b1);
        step(1'b1, SCORE, 1'b0, 1'b0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit         r;
            logic [1:0] st;
            r  = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : GAME;
            step(r, st, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1);
        end
        repeat (2) @(negedge pclk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
